// File: rtl/apb_master_arbiter.sv
// Two-requester APB master. Round-robin arbitration feeds a SETUP/ACCESS sequencer
// toward one slave, with PREADY wait states, an ACCESS timeout and per-requester responses.
module apb_master_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT       = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0]                   req_write,
    input  logic [2*ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]      req_wdata,
    output logic [1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDRESS_WIDTH-1:0]     PADDR,
    output logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH-1:0]        PRDATA,
    input  logic                         PREADY,
    input  logic                         PSLVERR
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            any_valid;
    logic            grant;
    logic            done;
    logic            tmo;
    logic            accept;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // Arbitration and handshake qualifiers
    always_comb begin
        any_valid = |req_valid;
        grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        done      = (state_q == ACCESS) && PREADY;
        // The counter holds TIMEOUT after that many stalled cycles; abort on the next one
        tmo       = (state_q == ACCESS) && !PREADY && (TIMEOUT != 0) && (tcnt_q == TO_VAL);
        accept    = any_valid && ((state_q == IDLE) || done);
        sel_write = grant ? req_write[1] : req_write[0];
        sel_addr  = grant ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        sel_wdata = grant ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (done)     state_d = accept ? SETUP : IDLE;
                else if (tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        PSEL      = (state_q != IDLE);
        PENABLE   = (state_q == ACCESS);
        req_ready = 2'b00;
        if (accept) req_ready = grant ? 2'b10 : 2'b01;
    end

    // Datapath next values
    always_comb begin
        last_grant_d = last_grant_q;
        tcnt_d       = tcnt_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;

        if (state_q == SETUP) begin
            tcnt_d = '0;
        end else if ((state_q == ACCESS) && !PREADY && (tcnt_q != TO_VAL)) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (accept) begin
            last_grant_d = grant;
            pwrite_d     = sel_write;
            paddr_d      = sel_addr;
            pwdata_d     = sel_write ? sel_wdata : '0;
        end else if (done || tmo) begin
            pwdata_d     = '0;
        end

        // last_grant_q still names the owner of the finishing transfer here
        if (done) begin
            rsp_valid_d[last_grant_q] = 1'b1;
            rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            rsp_err_d   = PSLVERR;
        end else if (tmo) begin
            rsp_valid_d[last_grant_q] = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant_q <= 1'b1;
            tcnt_q       <= '0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            tcnt_q       <= tcnt_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
